// File: rtl/onchip_dpram_avalon.sv
// True-dual-port on-chip RAM with two Avalon-MM slave ports on one clock.
// Generic width/depth, 1- or 2-cycle read latency, optional post-reset zero clear.

module onchip_dpram_avalon_rdpipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_en_i,
   input  logic [DATA_WIDTH-1:0] rd_word_i,
   output logic [DATA_WIDTH-1:0] readdata_o,
   output logic                  readdatavalid_o
);

   logic [DATA_WIDTH-1:0] stage1_data_q;
   logic                  stage1_valid_q;

   // Data only moves on a real read so readdata holds its last value between pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage1_data_q  <= '0;
         stage1_valid_q <= 1'b0;
      end else begin
         stage1_valid_q <= rd_en_i;
         if (rd_en_i) stage1_data_q <= rd_word_i;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] stage2_data_q;
      logic                  stage2_valid_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            stage2_data_q  <= '0;
            stage2_valid_q <= 1'b0;
         end else begin
            stage2_valid_q <= stage1_valid_q;
            if (stage1_valid_q) stage2_data_q <= stage1_data_q;
         end
      end

      assign readdata_o      = stage2_data_q;
      assign readdatavalid_o = stage2_valid_q;
   end else begin : g_lat1
      assign readdata_o      = stage1_data_q;
      assign readdatavalid_o = stage1_valid_q;
   end

endmodule

module onchip_dpram_avalon #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 16,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   s1_address,
   input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
   input  logic                    s1_chipselect,
   input  logic                    s1_read,
   input  logic                    s1_write,
   input  logic [DATA_WIDTH-1:0]   s1_writedata,
   output logic [DATA_WIDTH-1:0]   s1_readdata,
   output logic                    s1_readdatavalid,
   output logic                    s1_waitrequest,
   input  logic [ADDR_WIDTH-1:0]   s2_address,
   input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
   input  logic                    s2_chipselect,
   input  logic                    s2_read,
   input  logic                    s2_write,
   input  logic [DATA_WIDTH-1:0]   s2_writedata,
   output logic [DATA_WIDTH-1:0]   s2_readdata,
   output logic                    s2_readdatavalid,
   output logic                    s2_waitrequest,
   output logic                    init_done
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int DEPTH     = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic                  run, clr_we;
   logic                  s1_we, s1_re, s2_we, s2_re;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RESET;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_RESET: begin
            clr_cnt_d = '0;
            state_d   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         end
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == '1) state_d = ST_RUN;
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_RESET;
      endcase
   end

   // Reset gates acceptance immediately so nothing lands in the cycle reset is sampled.
   assign run            = (state_q == ST_RUN) && !reset;
   assign init_done      = run;
   assign s1_waitrequest = !run;
   assign s2_waitrequest = !run;
   assign clr_we         = (state_q == ST_CLEAR);

   assign s1_we = run && s1_chipselect && s1_write;
   assign s1_re = run && s1_chipselect && s1_read && !s1_write;
   assign s2_we = run && s2_chipselect && s2_write;
   assign s2_re = run && s2_chipselect && s2_read && !s2_write;

   always_ff @(posedge clk) begin
      // NOTE: the array itself is never reset; only the clear sequencer zeroes it.
      if (clr_we) mem_q[clr_cnt_q] <= '0;
      for (int b = 0; b < NUM_BYTES; b++) begin
         // NOTE: non-blocking writes keep same-cycle reads on the old word; s1 is last so it owns shared lanes.
         if (s2_we && s2_byteenable[b]) mem_q[s2_address][8*b +: 8] <= s2_writedata[8*b +: 8];
         if (s1_we && s1_byteenable[b]) mem_q[s1_address][8*b +: 8] <= s1_writedata[8*b +: 8];
      end
   end

   onchip_dpram_avalon_rdpipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_LATENCY(READ_LATENCY)
   ) u_rdpipe_s1 (
      .clk            (clk),
      .reset          (reset),
      .rd_en_i        (s1_re),
      .rd_word_i      (mem_q[s1_address]),
      .readdata_o     (s1_readdata),
      .readdatavalid_o(s1_readdatavalid)
   );

   onchip_dpram_avalon_rdpipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_LATENCY(READ_LATENCY)
   ) u_rdpipe_s2 (
      .clk            (clk),
      .reset          (reset),
      .rd_en_i        (s2_re),
      .rd_word_i      (mem_q[s2_address]),
      .readdata_o     (s2_readdata),
      .readdatavalid_o(s2_readdatavalid)
   );

endmodule

// File: tb/tb_onchip_dpram_avalon.sv
// Bench for onchip_dpram_avalon: latency-1 and latency-2 instances share stimulus;
// a byte-lane memory model feeds per-stream scoreboards of expected read data and due cycle.

module tb_onchip_dpram_avalon;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   typedef enum int {OP_IDLE, OP_READ, OP_WRITE, OP_RW, OP_CSOFF} op_e;
   typedef struct {
      op_e             op;
      logic [AW-1:0]   addr;
      logic [3:0]      be;
      logic [DW-1:0]   data;
   } req_t;
   typedef struct {
      int              due;
      logic [DW-1:0]   data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   logic [AW-1:0] addr_s [2];
   logic [3:0]    be_s   [2];
   logic          cs_s   [2];
   logic          rd_s   [2];
   logic          wr_s   [2];
   logic [DW-1:0] wd_s   [2];

   // Stream index: 0/1 = latency-1 s1/s2, 2/3 = latency-2 s1/s2.
   logic [DW-1:0] rdata_w [4];
   logic          vld_w   [4];
   logic          wreq_w  [4];
   logic          idone   [2];

   exp_t          sb_q [4][$];
   logic [DW-1:0] last_q [4];
   logic [DW-1:0] model [DEPTH];
   exp_t          mon_e;
   int            n_checks = 0;
   int            n_fail   = 0;

   onchip_dpram_avalon #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_l1 (
      .clk(clk), .reset(reset),
      .s1_address(addr_s[0]), .s1_byteenable(be_s[0]), .s1_chipselect(cs_s[0]), .s1_read(rd_s[0]),
      .s1_write(wr_s[0]), .s1_writedata(wd_s[0]), .s1_readdata(rdata_w[0]),
      .s1_readdatavalid(vld_w[0]), .s1_waitrequest(wreq_w[0]),
      .s2_address(addr_s[1]), .s2_byteenable(be_s[1]), .s2_chipselect(cs_s[1]), .s2_read(rd_s[1]),
      .s2_write(wr_s[1]), .s2_writedata(wd_s[1]), .s2_readdata(rdata_w[1]),
      .s2_readdatavalid(vld_w[1]), .s2_waitrequest(wreq_w[1]),
      .init_done(idone[0])
   );

   onchip_dpram_avalon #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_l2 (
      .clk(clk), .reset(reset),
      .s1_address(addr_s[0]), .s1_byteenable(be_s[0]), .s1_chipselect(cs_s[0]), .s1_read(rd_s[0]),
      .s1_write(wr_s[0]), .s1_writedata(wd_s[0]), .s1_readdata(rdata_w[2]),
      .s1_readdatavalid(vld_w[2]), .s1_waitrequest(wreq_w[2]),
      .s2_address(addr_s[1]), .s2_byteenable(be_s[1]), .s2_chipselect(cs_s[1]), .s2_read(rd_s[1]),
      .s2_write(wr_s[1]), .s2_writedata(wd_s[1]), .s2_readdata(rdata_w[3]),
      .s2_readdatavalid(vld_w[3]), .s2_waitrequest(wreq_w[3]),
      .init_done(idone[1])
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic req_t mk(op_e op, int addr = 0, logic [3:0] be = 4'hF, logic [DW-1:0] data = '0);
      req_t r;
      r.op   = op;
      r.addr = AW'(addr);
      r.be   = be;
      r.data = data;
      return r;
   endfunction

   function automatic req_t rand_req();
      int a;
      a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1));
      return mk(op_e'($urandom_range(0, 4)), a, 4'($urandom_range(0, 15)), $urandom);
   endfunction

   // Drives one cycle on both ports, books expected reads, updates the model, then advances.
   task automatic step(input req_t r1, input req_t r2, input bit skip_l2 = 1'b0);
      req_t r [2];
      exp_t e;
      r[0] = r1;
      r[1] = r2;
      for (int p = 0; p < 2; p++) begin
         cs_s[p]   = (r[p].op != OP_IDLE) && (r[p].op != OP_CSOFF);
         rd_s[p]   = r[p].op inside {OP_READ, OP_RW, OP_CSOFF};
         wr_s[p]   = r[p].op inside {OP_WRITE, OP_RW, OP_CSOFF};
         addr_s[p] = r[p].addr;
         be_s[p]   = r[p].be;
         wd_s[p]   = r[p].data;
         if (r[p].op == OP_READ) begin
            e.data = model[r[p].addr];
            e.due  = cyc + 1;
            sb_q[p].push_back(e);
            if (!skip_l2) begin
               e.due = cyc + 2;
               sb_q[2 + p].push_back(e);
            end
         end
      end
      for (int p = 1; p >= 0; p--) begin
         if (r[p].op inside {OP_WRITE, OP_RW}) begin
            for (int b = 0; b < 4; b++) begin
               if (r[p].be[b]) model[r[p].addr][8*b +: 8] = r[p].data[8*b +: 8];
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(mk(OP_IDLE), mk(OP_IDLE));
   endtask

   task automatic check_reset(input string tag);
      for (int s = 0; s < 4; s++) begin
         check($sformatf("%s_rdata%0d", tag, s), rdata_w[s], '0);
         check($sformatf("%s_valid%0d", tag, s), vld_w[s], 1'b0);
         check($sformatf("%s_wait%0d", tag, s), wreq_w[s], 1'b1);
         last_q[s] = '0;
      end
      for (int d = 0; d < 2; d++) check($sformatf("%s_init_done%0d", tag, d), idone[d], 1'b0);
   endtask

   // Called right after reset is released; expects DEPTH wait cycles then init_done on the next.
   task automatic wait_init(input string tag);
      int rise [2];
      int hi   [2];
      rise = '{0, 0};
      hi   = '{0, 0};
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (rise[d] == 0) begin
               if (idone[d]) rise[d] = n;
               else if (wreq_w[2*d] && wreq_w[2*d + 1]) hi[d]++;
            end
         end
         if (rise[0] != 0 && rise[1] != 0) break;
      end
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s_rise_l%0d", tag, d + 1), rise[d], DEPTH + 1);
         check($sformatf("%s_waithi_l%0d", tag, d + 1), hi[d], DEPTH);
      end
      for (int p = 0; p < 2; p++) begin
         cs_s[p] = 1'b0;
         rd_s[p] = 1'b0;
         wr_s[p] = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   task automatic check_hold(input string tag);
      for (int s = 0; s < 4; s++) check($sformatf("%s_%0d", tag, s), rdata_w[s], last_q[s]);
   endtask

   always @(negedge clk) begin
      for (int s = 0; s < 4; s++) begin
         if (vld_w[s]) begin
            if (sb_q[s].size() == 0) begin
               check($sformatf("unexpected_valid_l%0d_s%0d", s / 2 + 1, s % 2 + 1), vld_w[s], 1'b0);
            end else begin
               mon_e = sb_q[s].pop_front();
               check($sformatf("rdata_l%0d_s%0d", s / 2 + 1, s % 2 + 1), rdata_w[s], mon_e.data);
               check($sformatf("rlat_l%0d_s%0d", s / 2 + 1, s % 2 + 1), cyc, mon_e.due);
               last_q[s] = rdata_w[s];
            end
         end else if (sb_q[s].size() != 0 && sb_q[s][0].due < cyc) begin
            check($sformatf("missing_valid_l%0d_s%0d", s / 2 + 1, s % 2 + 1), vld_w[s], 1'b1);
            void'(sb_q[s].pop_front());
         end
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pend;
      for (int p = 0; p < 2; p++) begin
         addr_s[p] = '0;
         be_s[p]   = '0;
         cs_s[p]   = 1'b0;
         rd_s[p]   = 1'b0;
         wr_s[p]   = 1'b0;
         wd_s[p]   = '0;
      end
      for (int s = 0; s < 4; s++) last_q[s] = '0;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst0");

      // A read held during the clear must never be accepted.
      cs_s[0]   = 1'b1;
      rd_s[0]   = 1'b1;
      addr_s[0] = AW'(5);
      reset     = 1'b0;
      wait_init("init0");

      for (int i = 0; i < DEPTH; i++) step(mk(OP_READ, i), mk(OP_READ, DEPTH - 1 - i));

      step(mk(OP_WRITE, 3, 4'b0101, 32'hA5A5_A5A5), mk(OP_IDLE));
      step(mk(OP_READ, 3), mk(OP_IDLE));

      step(mk(OP_WRITE, 7, 4'b0011, 32'h1111_1111), mk(OP_WRITE, 7, 4'b1110, 32'h2222_2222));
      step(mk(OP_READ, 7), mk(OP_READ, 7));

      step(mk(OP_IDLE), mk(OP_WRITE, 5, 4'hF, 32'hDEAD_BEEF));
      step(mk(OP_WRITE, 5, 4'hF, 32'h1234_5678), mk(OP_READ, 5));
      step(mk(OP_IDLE), mk(OP_READ, 5));

      step(mk(OP_WRITE, 0, 4'hF, 32'd0), mk(OP_WRITE, 1, 4'hF, 32'd1));
      step(mk(OP_WRITE, 2, 4'hF, 32'd2), mk(OP_WRITE, 3, 4'hF, 32'd3));
      for (int i = 0; i < 4; i++) step(mk(OP_READ, i), mk(OP_IDLE));

      step(mk(OP_RW, 9, 4'hF, 32'h0000_0055), mk(OP_IDLE));
      step(mk(OP_READ, 9), mk(OP_IDLE));
      step(mk(OP_IDLE), mk(OP_WRITE, 3, 4'b0000, 32'hFFFF_FFFF));
      step(mk(OP_CSOFF, 2, 4'hF, 32'hFFFF_FFFF), mk(OP_READ, 3));
      step(mk(OP_READ, 2), mk(OP_IDLE));

      repeat (60) step(rand_req(), rand_req());
      idle(4);
      check_hold("hold");

      // Reads accepted just before reset: latency-1 data escapes, the latency-2 stage is flushed.
      step(mk(OP_READ, 1), mk(OP_READ, 2), 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset("rst_flush");
      @(posedge clk);
      #1;
      reset = 1'b0;
      wait_init("init1");

      step(mk(OP_WRITE, 10, 4'hF, 32'hCAFE_F00D), mk(OP_WRITE, 15, 4'hF, 32'h0BAD_0BAD));
      idle(2);

      // Reset for one cycle while the clear counter sits at 9.
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset("rst_mid");
      reset = 1'b0;
      wait_init("init2");

      for (int i = 0; i < DEPTH; i++) step(mk(OP_READ, DEPTH - 1 - i), mk(OP_READ, i));
      idle(4);

      pend = 0;
      for (int s = 0; s < 4; s++) pend += sb_q[s].size();
      check("scoreboard_drained", pend, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/onchip_dpram_avalon.md
Name: onchip_dpram_avalon

Overview:
Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2) sharing one clock. It succeeds the fixed 32-bit/64K-word single-port on-chip memory. New capabilities: generic width and depth, selectable 1- or 2-cycle pipelined read latency with readdatavalid, defined same-address collision rules, and an optional post-reset zero-clear sequencer. Sits on the system interconnect as shared program/data memory for two masters (e.g. CPU data port and DMA).

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8, range 8..128
ADDR_WIDTH, 16, word-address width; DEPTH = 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = zero every word after reset before serving traffic; 0 = contents undefined, ready immediately

Ports:
clk  in  1  single clock for both ports
reset  in  1  synchronous, active-high reset
sN_address  in  ADDR_WIDTH  word address, N = 1,2
sN_byteenable  in  DATA_WIDTH/8  byte-lane write enables
sN_chipselect  in  1  port select
sN_read  in  1  read request
sN_write  in  1  write request
sN_writedata  in  DATA_WIDTH  write data
sN_readdata  out  DATA_WIDTH  read data
sN_readdatavalid  out  1  one-cycle pulse, readdata valid
sN_waitrequest  out  1  high = request not accepted this cycle
init_done  out  1  high once memory is serviceable

Behaviour:
- Reset (sampled on clk while reset=1): sN_readdata=0, sN_readdatavalid=0, sN_waitrequest=1, init_done=0. Read pipeline flushed; in-flight reads never produce readdatavalid.
- FSM states:
  - RESET: held while reset=1.
  - CLEAR: only if CLEAR_ON_RESET=1. Entered the first cycle after reset falls. Counter starts at 0 and writes all-zero words at 1 word/cycle. Both waitrequests stay high. After the write to DEPTH-1, moves to RUN. Total time in CLEAR: exactly DEPTH cycles.
  - RUN: init_done=1, sN_waitrequest=0.
  - If CLEAR_ON_RESET=0, RESET goes directly to RUN in the first cycle after reset falls.
- Reset asserted in any state (including mid-CLEAR) returns to RESET; the clear counter restarts at 0.
- Acceptance: a transfer on port N is accepted when sN_chipselect & (sN_read | sN_write) & ~sN_waitrequest. No accepted transfers outside RUN.
- Read and write asserted together on one port: treated as a write; no readdatavalid is generated.
- Write: byte lane b of word[address] is updated at the clock edge of acceptance iff sN_byteenable[b]=1. Byteenable of all-zero is accepted but changes nothing.
- Dual write, same address, same cycle: lanes with s1_byteenable=1 take s1 data. Remaining lanes with s2_byteenable=1 take s2 data. Lanes enabled on neither port are unchanged.
- Read latency:
  - READ_LATENCY=1: sN_readdatavalid pulses in cycle T+1 for a read accepted in cycle T, with sN_readdata = word[address] as it was before any write in cycle T.
  - READ_LATENCY=2: same timing shifted to T+2 via an output register stage.
- Read-during-write: a read on either port to an address written in the same cycle (by either port) returns old data.
- Throughput: fully pipelined, one read or write per port per cycle; back-to-back reads give consecutive readdatavalid pulses in order.
- sN_readdata holds its last valid value while readdatavalid=0 (0 after reset).
- Address is always within range; no wrap logic needed beyond the ADDR_WIDTH truncation inherent in the port width.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_WIDTH=4: release reset -> waitrequest=1 for exactly 16 cycles, init_done rises on the 17th cycle; reads of addresses 0..15 return 0.
- RUN, s1 writes 0xA5A5A5A5 to addr 3 with BE=0b0101, then reads addr 3 (prior content 0) -> readdata=0x00A500A5, readdatavalid 1 cycle after read (2 with READ_LATENCY=2).
- Same cycle: s1 writes 0x11111111 BE=0b0011 and s2 writes 0x22222222 BE=0b1110, both to addr 7 -> addr 7 = 0x22221111.
- addr 5 holds 0xDEADBEEF; s2 reads addr 5 while s1 writes 0x12345678 there -> s2 gets 0xDEADBEEF; next read gets 0x12345678.
- s1 issues 4 back-to-back reads of addrs 0..3 holding 0..3, READ_LATENCY=2 -> four consecutive readdatavalid pulses with data 0,1,2,3 starting T+2.
- Assert reset for 1 cycle at clear counter=9 -> readdatavalid stays 0 throughout, clear restarts at 0, init_done rises DEPTH+1 cycles after reset falls.
